// File: rtl/motor_drive_controller.sv
// rtl/motor_drive_controller.sv - dual H-bridge drive: soft ramping, dead-timed reversal, period-aligned PWM
// One motor_side instance per wheel; the top owns command decode, ramp strobe and the shared PWM period.

module motor_side #(
  parameter int DEAD_CYCLES = 5_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ramp_stb,
  input  logic       pwm_wrap,
  input  logic [7:0] period_cnt,
  input  logic [7:0] tgt_duty,
  input  logic       tgt_rev,
  output logic       pwm,
  output logic       fwd,
  output logic       rev,
  output logic       idle
);
  localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_RAMPDN, S_DEAD} side_state_e;

  side_state_e   state_q, state_d;
  logic          rev_lat_q, rev_lat_d;
  logic [DW-1:0] dead_cnt_q, dead_cnt_d;
  logic [7:0]    cur_duty_q, cur_duty_d;
  logic [7:0]    pwm_duty_q, pwm_duty_d;
  logic          fwd_q, fwd_d;
  logic          rev_q, rev_d;
  logic          pwm_q, pwm_d;
  logic [7:0]    eff_duty;
  logic          tgt_on;
  logic          same_dir;

  assign tgt_on   = (tgt_duty != 8'd0);
  assign same_dir = (tgt_rev == rev_lat_q);

  always_comb begin
    state_d    = state_q;
    rev_lat_d  = rev_lat_q;
    dead_cnt_d = dead_cnt_q;
    eff_duty   = 8'd0;
    case (state_q)
      S_IDLE: begin
        if (tgt_on) begin
          rev_lat_d = tgt_rev;
          state_d   = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (!tgt_on || !same_dir) begin
          state_d = S_RAMPDN;
        end else begin
          eff_duty = tgt_duty;
        end
      end
      S_RAMPDN: begin
        // A command that returns to the latched direction resumes driving from the current duty.
        if (tgt_on && same_dir) begin
          state_d  = S_DRIVE;
          eff_duty = tgt_duty;
        end else if (cur_duty_q == 8'd0) begin
          if (!tgt_on) begin
            state_d = S_IDLE;
          end else begin
            state_d    = S_DEAD;
            dead_cnt_d = '0;
          end
        end
      end
      S_DEAD: begin
        if (dead_cnt_q == DEAD_LAST) begin
          if (tgt_on) begin
            rev_lat_d = tgt_rev;
            state_d   = S_DRIVE;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          dead_cnt_d = dead_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cur_duty_d = cur_duty_q;
    if (ramp_stb) begin
      if (cur_duty_q < eff_duty) begin
        cur_duty_d = cur_duty_q + 8'd1;
      end else if (cur_duty_q > eff_duty) begin
        cur_duty_d = cur_duty_q - 8'd1;
      end
    end
  end

  // Selects follow the next state so they change on the same edge as the FSM, never both high.
  always_comb begin
    fwd_d      = ((state_d == S_DRIVE) || (state_d == S_RAMPDN)) && !rev_lat_d;
    rev_d      = ((state_d == S_DRIVE) || (state_d == S_RAMPDN)) && rev_lat_d;
    pwm_duty_d = pwm_wrap ? cur_duty_q : pwm_duty_q;
    pwm_d      = (fwd_d || rev_d) && (period_cnt < pwm_duty_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rev_lat_q  <= 1'b0;
      dead_cnt_q <= '0;
      cur_duty_q <= 8'd0;
      pwm_duty_q <= 8'd0;
      fwd_q      <= 1'b0;
      rev_q      <= 1'b0;
      pwm_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rev_lat_q  <= rev_lat_d;
      dead_cnt_q <= dead_cnt_d;
      cur_duty_q <= cur_duty_d;
      pwm_duty_q <= pwm_duty_d;
      fwd_q      <= fwd_d;
      rev_q      <= rev_d;
      pwm_q      <= pwm_d;
    end
  end

  assign pwm  = pwm_q;
  assign fwd  = fwd_q;
  assign rev  = rev_q;
  assign idle = (state_q == S_IDLE);

endmodule

module motor_drive_controller #(
  parameter int         PWM_DIV     = 10,
  parameter int         RAMP_DIV    = 50_000,
  parameter int         DEAD_CYCLES = 5_000,
  parameter logic [7:0] DUTY_FULL   = 8'd230,
  parameter logic [7:0] DUTY_VEER   = 8'd110,
  parameter logic [7:0] DUTY_PIVOT  = 8'd160
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] DIR,
  output logic       l_pwm,
  output logic       l_fwd,
  output logic       l_rev,
  output logic       r_pwm,
  output logic       r_fwd,
  output logic       r_rev,
  output logic       stopped
);
  localparam int PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PW-1:0] PWM_LAST  = PW'(PWM_DIV - 1);
  localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_DIV - 1);

  logic [3:0]    dir_q;
  logic [PW-1:0] pre_q, pre_d;
  logic [RW-1:0] ramp_cnt_q, ramp_cnt_d;
  logic [7:0]    period_q, period_d;
  logic          stopped_q, stopped_d;
  logic          pwm_tick, pwm_wrap, ramp_stb;
  logic [7:0]    l_tgt_duty, r_tgt_duty;
  logic          l_tgt_rev, r_tgt_rev;
  logic          l_idle, r_idle;

  always_comb begin
    l_tgt_duty = 8'd0;
    r_tgt_duty = 8'd0;
    l_tgt_rev  = 1'b0;
    r_tgt_rev  = 1'b0;
    case (dir_q[3:2])
      2'b00: begin
        l_tgt_duty = DUTY_FULL;
        r_tgt_duty = DUTY_FULL;
      end
      2'b01: begin
        if (dir_q[1:0] == 2'b11) begin
          l_tgt_duty = DUTY_PIVOT;
          l_tgt_rev  = 1'b1;
          r_tgt_duty = DUTY_PIVOT;
        end else begin
          l_tgt_duty = DUTY_VEER;
          r_tgt_duty = DUTY_FULL;
        end
      end
      2'b10: begin
        if (dir_q[1:0] == 2'b11) begin
          l_tgt_duty = DUTY_PIVOT;
          r_tgt_duty = DUTY_PIVOT;
          r_tgt_rev  = 1'b1;
        end else begin
          l_tgt_duty = DUTY_FULL;
          r_tgt_duty = DUTY_VEER;
        end
      end
      default: begin
        l_tgt_duty = 8'd0;
        r_tgt_duty = 8'd0;
      end
    endcase
  end

  assign pwm_tick = (pre_q == PWM_LAST);
  assign pwm_wrap = pwm_tick && (period_q == 8'd254);
  assign ramp_stb = (ramp_cnt_q == RAMP_LAST);

  always_comb begin
    pre_d      = pwm_tick ? '0 : pre_q + 1'b1;
    ramp_cnt_d = ramp_stb ? '0 : ramp_cnt_q + 1'b1;
    period_d   = period_q;
    if (pwm_tick) begin
      period_d = (period_q == 8'd254) ? 8'd0 : period_q + 8'd1;
    end
    stopped_d = l_idle && r_idle;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dir_q      <= 4'b1111;
      pre_q      <= '0;
      ramp_cnt_q <= '0;
      period_q   <= 8'd0;
      stopped_q  <= 1'b1;
    end else begin
      dir_q      <= DIR;
      pre_q      <= pre_d;
      ramp_cnt_q <= ramp_cnt_d;
      period_q   <= period_d;
      stopped_q  <= stopped_d;
    end
  end

  motor_side #(.DEAD_CYCLES(DEAD_CYCLES)) u_left (
    .clk        (clk),
    .reset      (reset),
    .ramp_stb   (ramp_stb),
    .pwm_wrap   (pwm_wrap),
    .period_cnt (period_q),
    .tgt_duty   (l_tgt_duty),
    .tgt_rev    (l_tgt_rev),
    .pwm        (l_pwm),
    .fwd        (l_fwd),
    .rev        (l_rev),
    .idle       (l_idle)
  );

  motor_side #(.DEAD_CYCLES(DEAD_CYCLES)) u_right (
    .clk        (clk),
    .reset      (reset),
    .ramp_stb   (ramp_stb),
    .pwm_wrap   (pwm_wrap),
    .period_cnt (period_q),
    .tgt_duty   (r_tgt_duty),
    .tgt_rev    (r_tgt_rev),
    .pwm        (r_pwm),
    .fwd        (r_fwd),
    .rev        (r_rev),
    .idle       (r_idle)
  );

  assign stopped = stopped_q;

endmodule

// File: tb/tb_motor_drive_controller.sv
// tb/tb_motor_drive_controller.sv - scoreboard bench for motor_drive_controller
// Snapshot bits are {l_pwm,l_fwd,l_rev,r_pwm,r_fwd,r_rev,stopped}.

module tb_motor_drive_controller;
  logic       clk;
  logic       reset = 1'b1;
  logic [3:0] DIR = 4'b1111;
  logic       l_pwm, l_fwd, l_rev, r_pwm, r_fwd, r_rev, stopped;

  localparam logic [6:0] ALL  = 7'b1111111;
  localparam logic [6:0] SEL  = 7'b0110111;
  localparam logic [6:0] SELS = 7'b0110110;
  localparam logic [6:0] LDIR = 7'b0110000;

  typedef struct {
    string      name;
    bit         duty;
    logic [6:0] exp;
    logic [6:0] mask;
    int         exp_l;
    int         exp_r;
  } exp_t;

  exp_t sbq[$];
  bit   mon_busy = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   overlap_cnt = 0;
  bit   ok;

  motor_drive_controller #(
    .PWM_DIV     (1),
    .RAMP_DIV    (2),
    .DEAD_CYCLES (4),
    .DUTY_FULL   (8'd200),
    .DUTY_VEER   (8'd100),
    .DUTY_PIVOT  (8'd150)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .DIR     (DIR),
    .l_pwm   (l_pwm),
    .l_fwd   (l_fwd),
    .l_rev   (l_rev),
    .r_pwm   (r_pwm),
    .r_fwd   (r_fwd),
    .r_rev   (r_rev),
    .stopped (stopped)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if ((l_fwd && l_rev) || (r_fwd && r_rev)) overlap_cnt++;
  end

  // Monitor: one scoreboard entry per negedge; duty entries integrate one full PWM period.
  initial begin
    exp_t e;
    int lc, rc;
    logic [6:0] got;
    forever begin
      @(negedge clk);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        if (!e.duty) begin
          got = {l_pwm, l_fwd, l_rev, r_pwm, r_fwd, r_rev, stopped};
          total++;
          if ((got & e.mask) !== (e.exp & e.mask)) begin
            bad++;
            $display("FAIL %s: got=%b want=%b mask=%b", e.name, got, e.exp, e.mask);
          end
        end else begin
          mon_busy = 1'b1;
          lc = 0;
          rc = 0;
          for (int i = 0; i < 255; i++) begin
            if (i > 0) @(negedge clk);
            lc += int'(l_pwm);
            rc += int'(r_pwm);
          end
          total++;
          if (lc != e.exp_l || rc != e.exp_r) begin
            bad++;
            $display("FAIL %s: got l=%0d r=%0d want l=%0d r=%0d", e.name, lc, rc, e.exp_l, e.exp_r);
          end
          mon_busy = 1'b0;
        end
      end
    end
  end

  task automatic push_snap(input string nm, input logic [6:0] e, input logic [6:0] m);
    exp_t x;
    x.name = nm; x.duty = 1'b0; x.exp = e; x.mask = m; x.exp_l = 0; x.exp_r = 0;
    sbq.push_back(x);
  endtask

  task automatic push_duty(input string nm, input int el, input int er);
    exp_t x;
    x.name = nm; x.duty = 1'b1; x.exp = '0; x.mask = '0; x.exp_l = el; x.exp_r = er;
    sbq.push_back(x);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string nm, input int bound);
    int k;
    k = 0;
    while ((sbq.size() != 0 || mon_busy) && k < bound) begin
      cyc(1);
      k++;
    end
    if (sbq.size() != 0 || mon_busy) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard not drained after %0d cycles, %0d left", nm, bound, sbq.size());
      sbq.delete();
    end
  endtask

  // what=0: left forward select dropped; what=1: every select low.
  task automatic poll(input string nm, input int what, input int bound, output bit found);
    found = 1'b0;
    for (int k = 0; k < bound; k++) begin
      cyc(1);
      if ((what == 0 && !l_fwd) || (what == 1 && !(l_fwd || l_rev || r_fwd || r_rev))) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      total++;
      bad++;
      $display("FAIL %s: condition not seen within %0d cycles, got=0 want=1", nm, bound);
    end
  endtask

  initial begin
    push_snap("reset_state", 7'b0000001, ALL);
    cyc(3);
    reset = 1'b0;
    cyc(3);
    push_snap("idle_after_release", 7'b0000001, ALL);
    wait_drain("drain_idle", 10);

    DIR = 4'b0000;
    push_snap("fwd_lat0", 7'b0000001, SEL);
    push_snap("fwd_lat1", 7'b0000001, SEL);
    push_snap("fwd_lat2", 7'b0100101, SEL);
    push_snap("fwd_lat3", 7'b0100100, SEL);
    wait_drain("drain_lat", 10);
    cyc(700);
    push_duty("duty_full", 200, 200);
    wait_drain("drain_full", 400);

    DIR = 4'b0101;
    for (int i = 0; i < 450; i++) push_snap("veer_sel", 7'b0100100, SEL);
    wait_drain("drain_veer", 1000);
    cyc(300);
    push_duty("duty_veer", 100, 200);
    wait_drain("drain_veer_duty", 400);

    DIR = 4'b0000;
    cyc(700);
    push_duty("duty_full2", 200, 200);
    wait_drain("drain_full2", 400);

    DIR = 4'b0111;
    poll("pivot_rampdn", 0, 1500, ok);
    if (ok) begin
      push_snap("dead1", 7'b0000100, 7'b1110110);
      push_snap("dead2", 7'b0000100, 7'b1110110);
      push_snap("dead3", 7'b0000100, 7'b1110110);
      push_snap("dead4", 7'b0000100, 7'b1110110);
      push_snap("rev_on", 7'b0010100, SELS);
    end
    wait_drain("drain_dead", 20);
    cyc(800);
    push_snap("pivot_sel", 7'b0010100, SEL);
    push_duty("duty_pivot", 150, 150);
    wait_drain("drain_pivot", 400);

    DIR = 4'b0000;
    for (int i = 0; i < 100; i++) push_snap("abort_rampdn", 7'b0010000, LDIR);
    cyc(100);
    DIR = 4'b0111;
    for (int i = 0; i < 400; i++) push_snap("abort_redrive", 7'b0010000, LDIR);
    wait_drain("drain_abort", 1000);
    push_duty("duty_abort", 150, 150);
    wait_drain("drain_abort_duty", 400);

    DIR = 4'b1111;
    poll("stop_sel_low", 1, 1500, ok);
    if (ok) begin
      push_snap("stop_last_idle", 7'b0000000, ALL);
      push_snap("stop_flag", 7'b0000001, ALL);
      push_snap("stop_hold", 7'b0000001, ALL);
    end
    wait_drain("drain_stop", 20);

    DIR = 4'b0000;
    cyc(700);
    DIR = 4'b0111;
    poll("dead_entry", 0, 1500, ok);
    cyc(1);
    reset = 1'b1;
    DIR = 4'b1111;
    push_snap("reset_mid_dead", 7'b0000001, ALL);
    wait_drain("drain_rst_dead", 10);
    cyc(2);
    reset = 1'b0;
    cyc(20);
    for (int i = 0; i < 3; i++) push_snap("after_rst_dead", 7'b0000001, ALL);
    wait_drain("drain_after_dead", 10);

    DIR = 4'b0000;
    cyc(150);
    reset = 1'b1;
    DIR = 4'b1111;
    push_snap("reset_mid_ramp", 7'b0000001, ALL);
    wait_drain("drain_rst_ramp", 10);
    cyc(2);
    reset = 1'b0;
    cyc(10);
    for (int i = 0; i < 3; i++) push_snap("after_rst_ramp", 7'b0000001, ALL);
    wait_drain("drain_after_ramp", 10);

    total++;
    if (overlap_cnt != 0) begin
      bad++;
      $display("FAIL no_overlap: got=%0d cycles with fwd&rev want=0", overlap_cnt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/motor_drive_controller.md
Name: motor_drive_controller

Overview:
- Consumes the 4-bit steering command DIR from the direction-control stage.
- Drives the left and right H-bridge channels: one PWM enable plus forward/reverse select lines per side.
- Per side: duty-cycle ramping (soft start/stop), safe direction reversal (ramp to zero, then dead time, then reverse), and glitch-free PWM whose duty updates only at period boundaries.
- Sits between steering logic and the motor driver pins.

Parameters:
- PWM_DIV, 10, clk cycles per PWM tick (50 MHz/10/255 ≈ 19.6 kHz PWM).
- RAMP_DIV, 50_000, clk cycles per ±1 duty step.
- DEAD_CYCLES, 5_000, clk cycles with both bridge selects low before a reversal.
- DUTY_FULL, 8'd230, duty for straight drive and outer wheel.
- DUTY_VEER, 8'd110, inner-wheel duty when veering.
- DUTY_PIVOT, 8'd160, duty for both wheels in a 90-degree pivot.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- DIR  in  4  steering command; [3:2] 00 proceed/01 left/10 right/11 stop; [1:0] 00 full/01 veer/11 90-degree
- l_pwm  out  1  left bridge enable (PWM)
- l_fwd  out  1  left forward select
- l_rev  out  1  left reverse select
- r_pwm  out  1  right bridge enable
- r_fwd  out  1  right forward select
- r_rev  out  1  right reverse select
- stopped  out  1  high when both sides are IDLE with duty 0

Behaviour:
- Reset is asynchronous and active-high. On reset all outputs go to 0 immediately; stopped=1. Duties, counters and timers clear, both sides go to IDLE, and the registered command becomes stop. This holds mid-ramp or mid-dead-time as well.
- DIR is registered once; the target decode uses the registered value (1-cycle latency).
- Target decode, as (left dir/duty, right dir/duty):
  - 00_xx: fwd/FULL, fwd/FULL.
  - 01_11: rev/PIVOT, fwd/PIVOT.
  - 10_11: fwd/PIVOT, rev/PIVOT.
  - 01_00, 01_01, 01_10: fwd/VEER, fwd/FULL.
  - 10_00, 10_01, 10_10: fwd/FULL, fwd/VEER.
  - 11_xx: target 0 on both sides, no direction.
- Ramp:
  - A shared ramp strobe pulses once every RAMP_DIV clks.
  - On each strobe, each side's cur_duty moves by 1 toward its effective target. It never overshoots and saturates at 0 and 255.
- Per-side FSM (two identical instances):
  - IDLE: fwd=rev=0, cur_duty=0. If the target duty is >0, latch the target direction and go to DRIVE.
  - DRIVE: select line for the latched direction is high. Effective target = target duty.
    - If the target direction differs from the latched one, or the target is 0, go to RAMPDN.
  - RAMPDN: latched select stays high; effective target = 0. When cur_duty reaches 0:
    - target 0 → IDLE;
    - direction differs → DEAD;
    - target now matches the latched direction again → DRIVE.
  - DEAD: fwd=rev=0 for exactly DEAD_CYCLES clks. Then, if target >0, latch the new direction and go to DRIVE; otherwise go to IDLE.
  - fwd and rev are never both 1 in any state or cycle.
- PWM:
  - A prescaler produces a tick every PWM_DIV clks.
  - An 8-bit period counter counts 0..254 on ticks and wraps to 0.
  - At wrap, each side samples cur_duty into pwm_duty.
  - x_pwm = (period_cnt < pwm_duty), registered: duty 0 gives constant low; duty 255 gives constant high.
  - x_pwm is forced to 0 whenever that side's fwd and rev are both 0.
- stopped is registered: 1 iff both FSMs are in IDLE.
- Command changes mid-ramp retarget immediately. The ramp continues from the current duty, with no restart.
- A new command arriving during DEAD does not shorten the dead time.

Test Plan (bench overrides: PWM_DIV=1, RAMP_DIV=2, DEAD_CYCLES=4, DUTY_FULL=200, DUTY_VEER=100, DUTY_PIVOT=150):
- Reset, then DIR=4'b00_00 → both sides enter DRIVE with fwd=1. cur_duty rises 1 per 2 clks to 200 and holds. After the next period wrap, l_pwm/r_pwm are high 200 of every 255 ticks; stopped=0.
- From steady proceed, DIR=4'b01_01 → left ramps 200→100 with l_fwd held; right stays 200; no select glitch.
- From steady proceed, DIR=4'b01_11:
  - Left ramps 200→0, then l_fwd=l_rev=0 and l_pwm=0 for exactly 4 clks, then l_rev=1 and ramps to 150.
  - Right ramps 200→150 forward.
  - Assert fwd&rev is never 1.
- DIR=4'b11_11 from any motion → both ramp to 0, then selects drop to 0, and stopped=1 one clk after both reach IDLE.
- Assert reset mid-DEAD and mid-ramp → all outputs 0 within the same cycle (asynchronous). After release with DIR=11_11, outputs stay 0 and stopped=1.
- During RAMPDN toward reverse, return DIR to the original direction before duty reaches 0 → the FSM goes straight back to DRIVE with no DEAD phase and ramps up from the current duty.
